// File: rtl/seq_divider16_pkg.sv
// Shared types and constants for the sequential 16-bit divider.
// Imported by the divider top and its trial-subtract stage.
package seq_divider16_pkg;

   localparam int          DIV_W    = 16;
   localparam int          DIV_CW   = 5;
   localparam logic [15:0] DBZ_QUOT = 16'hFFFF;
   localparam logic [15:0] SMIN     = 16'h8000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ITER,
      ST_FIXUP,
      ST_DONE
   } state_t;

endpackage

// File: rtl/seq_divider16_trial_sub.sv
// Combinational trial subtract for one restoring-division step.
// Reports the low W bits of the difference and whether it went negative.
module seq_divider16_trial_sub
   import seq_divider16_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic [W:0]   a_i,
   input  logic [W:0]   b_i,
   output logic [W-1:0] diff_o,
   output logic         borrow_o
);

   // A non-negative result is always below the divisor, so W bits suffice.
   assign diff_o   = a_i[W-1:0] - b_i[W-1:0];
   assign borrow_o = (a_i < b_i);

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or
// unsigned, with start/done handshake and divide-by-zero/overflow flags.
module seq_divider16
   import seq_divider16_pkg::*;
#(
   parameter int W     = DIV_W,
   parameter int CNT_W = DIV_CW
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sign,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_by_zero,
   output logic         ovflow
);

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             sign_q, sign_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [W-1:0]     bmag_q, bmag_d;
   logic [W-1:0]     racc_q, racc_d;
   logic [W-1:0]     qacc_q, qacc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     quot_q, quot_d;
   logic [W-1:0]     rmd_q, rmd_d;
   logic             dbz_q, dbz_d;
   logic             ovf_q, ovf_d;

   logic [W-1:0]     amag;
   logic [W-1:0]     bmag;
   logic [W:0]       shifted;
   logic [W-1:0]     diff;
   logic             borrow;

   assign amag    = (sign_q & a_q[W-1]) ? -a_q : a_q;
   assign bmag    = (sign_q & b_q[W-1]) ? -b_q : b_q;
   assign shifted = {racc_q, qacc_q[W-1]};

   seq_divider16_trial_sub #(.W(W)) u_trial (
      .a_i      (shifted),
      .b_i      ({1'b0, bmag_q}),
      .diff_o   (diff),
      .borrow_o (borrow)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sign_d  = sign_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      bmag_d  = bmag_q;
      racc_d  = racc_q;
      qacc_d  = qacc_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SETUP;
               a_d     = dividend;
               b_d     = divisor;
               sign_d  = sign;
               dbz_d   = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         ST_SETUP: begin
            qneg_d = sign_q & (a_q[W-1] ^ b_q[W-1]);
            rneg_d = sign_q & a_q[W-1];
            bmag_d = bmag;
            if (b_q == '0) begin
               state_d = ST_DONE;
               quot_d  = DBZ_QUOT;
               rmd_d   = a_q;
               dbz_d   = 1'b1;
            end else begin
               state_d = ST_ITER;
               cnt_d   = '0;
               racc_d  = '0;
               qacc_d  = amag;
            end
         end
         ST_ITER: begin
            racc_d = borrow ? shifted[W-1:0] : diff;
            qacc_d = {qacc_q[W-2:0], ~borrow};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(W - 1)) begin
               state_d = ST_FIXUP;
            end
         end
         ST_FIXUP: begin
            // Truncating division: remainder follows the dividend sign.
            quot_d  = qneg_q ? -qacc_q : qacc_q;
            rmd_d   = rneg_q ? -racc_q : racc_q;
            ovf_d   = sign_q & (a_q == SMIN) & (b_q == '1);
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         bmag_q  <= '0;
         racc_q  <= '0;
         qacc_q  <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sign_q  <= sign_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         bmag_q  <= bmag_d;
         racc_q  <= racc_d;
         qacc_q  <= qacc_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign quotient    = quot_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;
   assign ovflow      = ovf_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Scoreboard bench for seq_divider16: expected results queued at start,
// compared when done pulses; latency, handshake and reset abort checked.
module tb_seq_divider16;

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sign;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;
   logic        ovflow;

   int   n_chk;
   int   n_fail;
   exp_t sb_q[$];

   seq_divider16 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .sign        (sign),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .ovflow      (ovflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a,
                                  input logic [15:0] b,
                                  input logic s);
      exp_t e;
      int   sa, sb;
      e = '0;
      if (b == 16'h0000) begin
         e.q   = 16'hFFFF;
         e.r   = a;
         e.dbz = 1'b1;
      end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
         e.q   = 16'h8000;
         e.r   = 16'h0000;
         e.ovf = 1'b1;
      end else if (s) begin
         sa  = int'($signed(a));
         sb  = int'($signed(b));
         e.q = 16'(sa / sb);
         e.r = 16'(sa % sb);
      end else begin
         e.q = 16'(int'(a) / int'(b));
         e.r = 16'(int'(a) % int'(b));
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("quotient", 32'(quotient), 32'(e.q));
            check("remainder", 32'(remainder), 32'(e.r));
            check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            check("ovflow", 32'(ovflow), 32'(e.ovf));
            check("busy_at_done", 32'(busy), 32'd1);
         end
      end
   end

   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input int poke);
      int lat;
      int exp_lat;
      exp_lat = (b == 16'h0000) ? 1 : 18;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      sign     = s;
      start    = 1'b1;
      sb_q.push_back(model(a, b, s));
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         if (n == poke) begin
            dividend = 16'h0064;
            divisor  = 16'h0003;
            sign     = ~s;
            start    = 1'b1;
         end
         @(posedge clk);
         #1;
         if (n == poke) begin
            start = 1'b0;
            check("busy_poke", 32'(busy), 32'd1);
         end
         if (done) begin
            lat = n;
            break;
         end
      end
      check("latency", 32'(lat), 32'(exp_lat));
      @(posedge clk);
      #1;
      check("done_pulse_end", 32'(done), 32'd0);
      check("idle_not_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      sign     = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quot", 32'(quotient), 32'd0);
      check("rst_rem", 32'(remainder), 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      check("rst_ovf", 32'(ovflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(16'hF123, 16'h1345, 1'b0, 0);
      run_op(16'hFF9C, 16'h0007, 1'b1, 0);
      run_op(16'hF123, 16'h1345, 1'b1, 0);
      run_op(16'h1234, 16'h0000, 1'b1, 0);
      run_op(16'h1234, 16'h0000, 1'b0, 0);
      run_op(16'h8000, 16'hFFFF, 1'b1, 0);
      run_op(16'h8000, 16'hFFFF, 1'b0, 0);
      run_op(16'h7FFF, 16'h0001, 1'b1, 0);
      run_op(16'h0005, 16'hFFFE, 1'b1, 0);
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
      run_op(16'h0003, 16'h0007, 1'b0, 0);

      // Start during the fifth iteration must be ignored.
      run_op(16'hABCD, 16'h0123, 1'b0, 6);

      for (int i = 0; i < 10; i++) begin
         run_op(16'($urandom), 16'($urandom_range(1, 65535)),
                1'($urandom), 0);
      end

      @(negedge clk);
      dividend = 16'h4321;
      divisor  = 16'h0011;
      sign     = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_quot", 32'(quotient), 32'd0);
      check("abort_rem", 32'(remainder), 32'd0);
      check("abort_dbz", 32'(div_by_zero), 32'd0);
      check("abort_ovf", 32'(ovflow), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("abort_stays_idle", 32'(busy), 32'd0);

      run_op(16'hFF9C, 16'h0007, 1'b1, 0);
      run_op(16'h4321, 16'h0011, 1'b0, 0);

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
